// File: rtl/sprite_load_sched_pkg.sv
// ---------------------------------------------------------------------------
// sprite_load_sched_pkg
// Shared constants and types for the bird sprite loader and the renderer that
// reads the sprite RAM back.
//   FRAME_WORDS_DEF  words per bird frame (50x35 pixels)
//   NUM_FRAMES_DEF   frames stored: up, mid, down
//   TOTAL_WORDS_DEF  size of a complete texture set in the sprite RAM
//   ANIM_DIV_DEF     frame_tick pulses per flap animation step
//   load_state_t     loader state encoding
// ---------------------------------------------------------------------------
package sprite_load_sched_pkg;

   localparam int FRAME_WORDS_DEF = 1750;
   localparam int NUM_FRAMES_DEF  = 3;
   localparam int TOTAL_WORDS_DEF = FRAME_WORDS_DEF * NUM_FRAMES_DEF;
   localparam int ANIM_DIV_DEF    = 10;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   // The mid frame is what the renderer shows whenever the bird is not flapping.
   localparam logic [1:0] ANIM_IDX_MID = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } load_state_t;

   // Flap order is up -> mid -> down -> up; index 2 wraps back to 0.
   function automatic logic [1:0] next_anim_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Start address of a frame inside the sprite RAM.
   function automatic logic [ADDR_W-1:0] anim_base_of(input logic [1:0] idx,
                                                      input int frame_words);
      return ADDR_W'(int'(idx) * frame_words);
   endfunction

endpackage

// File: rtl/sprite_load_sched_anim.sv
// ---------------------------------------------------------------------------
// sprite_anim_step
// Flap animation divider and frame index stepper.
//   clk, rst  clock and asynchronous active-high reset
//   tick      one pulse per displayed frame
//   enable    animation enabled
//   hold      force the mid frame and clear the divider
//   idx       current frame index (0 up, 1 mid, 2 down)
//   base      registered read base address, idx*FRAME_WORDS
// ---------------------------------------------------------------------------
module sprite_anim_step
   import sprite_load_sched_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int ANIM_DIV    = ANIM_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              enable,
   input  logic              hold,
   output logic [1:0]        idx,
   output logic [ADDR_W-1:0] base
);

   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       idx_step;

   assign idx_step = next_anim_idx(idx);

   // Divider and index advance together. base is computed from the index being
   // loaded so both registers change on the same edge, and the renderer never
   // sees an index paired with a stale base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= ANIM_IDX_MID;
         base    <= anim_base_of(ANIM_IDX_MID, FRAME_WORDS);
      end else if (hold || !enable) begin
         div_cnt <= '0;
         idx     <= ANIM_IDX_MID;
         base    <= anim_base_of(ANIM_IDX_MID, FRAME_WORDS);
      end else if (tick) begin
         if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx_step;
            base    <= anim_base_of(idx_step, FRAME_WORDS);
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_load_sched.sv
// ---------------------------------------------------------------------------
// sprite_load_sched
// Streams a bird texture set (NUM_FRAMES frames of FRAME_WORDS RGB565 words)
// from a valid/ready source into the sprite RAM, then runs the flap animation.
//   clk, rst     clock and asynchronous active-high reset
//   start        pulse requesting a texture load (ignored while loading)
//   src_valid    source word valid
//   src_data     source RGB565 word
//   src_ready    loader accepts a word this cycle
//   frame_tick   pulse per displayed frame
//   anim_en      flap animation enable
//   wr_en        sprite RAM write enable
//   wr_addr      sprite RAM write address
//   wr_data      sprite RAM write data
//   busy         load in progress or final write still pending
//   done         sprite RAM holds a complete texture set
//   anim_idx     current frame index
//   anim_base    read base address of the current frame
// ---------------------------------------------------------------------------
module sprite_load_sched
   import sprite_load_sched_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
   parameter int ANIM_DIV    = ANIM_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   input  logic              frame_tick,
   input  logic              anim_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        anim_idx,
   output logic [ADDR_W-1:0] anim_base
);

   localparam int TOTAL_WORDS = FRAME_WORDS * NUM_FRAMES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);

   load_state_t       state;
   load_state_t       state_next;
   logic [ADDR_W-1:0] word_cnt;
   logic              accept;
   logic              last_word;
   logic              load_start;
   logic              anim_hold;

   assign accept     = src_valid & src_ready;
   assign last_word  = (word_cnt == LAST_ADDR);
   assign load_start = start & (state != ST_LOAD);

   // A new load forces the mid frame in the same edge that clears done, so a
   // frame_tick arriving with start can never step the animation.
   assign anim_hold  = ~done | load_start;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: start only matters outside LOAD; LOAD ends on the
   // acceptance of the last word of the set.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (start) state_next = ST_LOAD;
         ST_LOAD:  if (accept && last_word) state_next = ST_READY;
         ST_READY: if (start) state_next = ST_LOAD;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state. busy stays up for the cycle of the final
   // write, after the state has already moved on to READY.
   always_comb begin
      src_ready = 1'b0;
      busy      = wr_en;
      if (state == ST_LOAD) begin
         src_ready = 1'b1;
         busy      = 1'b1;
      end
   end

   // Write pipeline and word counter. Each accepted word is written one cycle
   // later at the counter value it was accepted with. The counter wraps to 0
   // after the last word so it never holds an address beyond the RAM, and done
   // rises on the same edge that launches the final write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
      end else begin
         wr_en <= accept;
         if (accept) begin
            wr_addr <= word_cnt;
            wr_data <= src_data;
         end
         if (load_start) begin
            word_cnt <= '0;
            done     <= 1'b0;
         end else if (accept) begin
            if (last_word) begin
               word_cnt <= '0;
               done     <= 1'b1;
            end else begin
               word_cnt <= word_cnt + ADDR_W'(1);
            end
         end
      end
   end

   sprite_anim_step #(
      .FRAME_WORDS (FRAME_WORDS),
      .ANIM_DIV    (ANIM_DIV)
   ) u_anim (
      .clk    (clk),
      .rst    (rst),
      .tick   (frame_tick),
      .enable (anim_en),
      .hold   (anim_hold),
      .idx    (anim_idx),
      .base   (anim_base)
   );

endmodule

// File: tb/tb_sprite_load_sched.sv
// ---------------------------------------------------------------------------
// tb_sprite_load_sched
// Self-checking bench for sprite_load_sched with default parameters
// (1750 words per frame, 3 frames, 5250 words total, ANIM_DIV 10).
// ---------------------------------------------------------------------------
module tb_sprite_load_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        src_valid;
   logic [15:0] src_data;
   logic        src_ready;
   logic        frame_tick;
   logic        anim_en;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic [1:0]  anim_idx;
   logic [12:0] anim_base;

   int n_compared   = 0;
   int n_mismatched = 0;
   int acc_cnt      = 0;
   int wr_count     = 0;
   int wc_before;

   typedef struct packed {
      logic [12:0] addr;
      logic [15:0] data;
   } wr_rec_t;

   typedef struct {
      logic        en;
      logic        tick;
      logic [1:0]  exp_idx;
      logic [12:0] exp_base;
   } anim_vec_t;

   wr_rec_t   exp_q[$];
   anim_vec_t vecs[$];

   bit      model_loading = 1'b0;
   bit      done_model    = 1'b0;
   bit      pending;
   int      model_addr    = 0;
   wr_rec_t rec;

   sprite_load_sched dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .frame_tick (frame_tick),
      .anim_en    (anim_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .anim_idx   (anim_idx),
      .anim_base  (anim_base)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs shortly after a rising edge, note whether the
   // word will be accepted, then wait for the next edge plus settling time.
   task automatic applyStimulus(input bit st, input bit vld, input bit tk,
                                input bit en, input logic [15:0] dat);
      start      = st;
      src_valid  = vld;
      frame_tick = tk;
      anim_en    = en;
      src_data   = dat;
      if (vld && src_ready) acc_cnt++;
      @(posedge clk);
      #1;
   endtask

   function automatic void addVecs(input int n, input logic en, input logic tick,
                                   input logic [1:0] idx, input logic [12:0] base);
      anim_vec_t v;
      v.en       = en;
      v.tick     = tick;
      v.exp_idx  = idx;
      v.exp_base = base;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   // Write scoreboard, sampled on the falling edge. Each word seen accepted
   // before an edge must appear as exactly one write right after that edge at
   // the next sequential address; any other cycle must have no write. Also
   // tracks the expected src_ready, busy and done, and that the mid frame is
   // shown whenever no complete texture set is present.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_loading = 1'b0;
         model_addr    = 0;
         done_model    = 1'b0;
      end else begin
         pending = (exp_q.size() > 0);
         checkOutput("busy", {31'd0, busy}, {31'd0, (model_loading | pending)});
         checkOutput("src_ready", {31'd0, src_ready}, {31'd0, model_loading});
         if (pending) begin
            rec = exp_q.pop_front();
            wr_count++;
            checkOutput("wr_en", {31'd0, wr_en}, 32'd1);
            checkOutput("wr_addr", {19'd0, wr_addr}, {19'd0, rec.addr});
            checkOutput("wr_data", {16'd0, wr_data}, {16'd0, rec.data});
            if (rec.addr == 13'd5249) done_model = 1'b1;
         end else begin
            checkOutput("wr_en_idle", {31'd0, wr_en}, 32'd0);
         end
         checkOutput("done", {31'd0, done}, {31'd0, done_model});
         if (!done_model) checkOutput("anim_idx_held", {30'd0, anim_idx}, 32'd1);
         if (model_loading) begin
            if (src_valid) begin
               exp_q.push_back({13'(model_addr), src_data});
               if (model_addr == 5249) model_loading = 1'b0;
               else model_addr++;
            end
         end else if (start) begin
            model_loading = 1'b1;
            model_addr    = 0;
            done_model    = 1'b0;
         end
      end
   end

   // Hard stop in case the design stalls the bench.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Animation vectors: {anim_en, frame_tick} -> {anim_idx, anim_base}
      // after the edge, starting from a fresh load (divider 0, mid frame).
      addVecs(9, 1'b1, 1'b1, 2'd1, 13'd1750);   // ticks 1-9
      addVecs(2, 1'b1, 1'b0, 2'd1, 13'd1750);   // no tick, no change
      addVecs(1, 1'b1, 1'b1, 2'd2, 13'd3500);   // tick 10
      addVecs(9, 1'b1, 1'b1, 2'd2, 13'd3500);   // ticks 11-19
      addVecs(1, 1'b1, 1'b1, 2'd0, 13'd0);      // tick 20
      addVecs(9, 1'b1, 1'b1, 2'd0, 13'd0);      // ticks 21-29
      addVecs(1, 1'b1, 1'b1, 2'd1, 13'd1750);   // tick 30
      addVecs(3, 1'b1, 1'b1, 2'd1, 13'd1750);   // divider to 3
      addVecs(1, 1'b0, 1'b1, 2'd1, 13'd1750);   // disabled: divider cleared
      addVecs(9, 1'b1, 1'b1, 2'd1, 13'd1750);   // nine more ticks
      addVecs(1, 1'b1, 1'b1, 2'd2, 13'd3500);   // tenth after clear

      rst        = 1'b1;
      start      = 1'b0;
      src_valid  = 1'b0;
      src_data   = 16'd0;
      frame_tick = 1'b0;
      anim_en    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      checkOutput("rst_anim_idx", {30'd0, anim_idx}, 32'd1);
      checkOutput("rst_anim_base", {19'd0, anim_base}, 32'd1750);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_src_ready", {31'd0, src_ready}, 32'd0);
      checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_wr_addr", {19'd0, wr_addr}, 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Gappy load with a stray start mid-load, aborted by reset after word 800.
      $display("[TB] toggled-valid load, reset after word 800");
      acc_cnt = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < 3000 && acc_cnt < 801; i++)
         applyStimulus(i == 300, (i % 2) == 0, 1'b0, 1'b0, 16'h8000 | 16'(acc_cnt));
      checkOutput("load1_words", acc_cnt, 32'd801);
      checkOutput("load1_wr_en_800", {31'd0, wr_en}, 32'd1);
      checkOutput("load1_wr_addr_800", {19'd0, wr_addr}, 32'd800);
      rst       = 1'b1;
      src_valid = 1'b0;
      #1;
      checkOutput("abort_src_ready", {31'd0, src_ready}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Full load with valid held high and data equal to address.
      $display("[TB] full load of 5250 words");
      wc_before = wr_count;
      acc_cnt   = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'(acc_cnt));
      for (int i = 0; i < 5400 && acc_cnt < 5250; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'(acc_cnt));
      checkOutput("load2_words", acc_cnt, 32'd5250);
      checkOutput("final_src_ready", {31'd0, src_ready}, 32'd0);
      checkOutput("final_done", {31'd0, done}, 32'd1);
      checkOutput("final_wr_en", {31'd0, wr_en}, 32'd1);
      checkOutput("final_wr_addr", {19'd0, wr_addr}, 32'd5249);
      checkOutput("final_wr_data", {16'd0, wr_data}, 32'd5249);
      checkOutput("final_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'(acc_cnt));
      checkOutput("load2_write_count", wr_count - wc_before, 32'd5250);
      checkOutput("ready_busy", {31'd0, busy}, 32'd0);
      checkOutput("ready_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("ready_done", {31'd0, done}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Flap animation from the vector table.
      $display("[TB] animation vectors: %0d", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(1'b0, 1'b0, vecs[i].tick, vecs[i].en, 16'd0);
         checkOutput($sformatf("anim_idx_v%0d", i), {30'd0, anim_idx}, {30'd0, vecs[i].exp_idx});
         checkOutput($sformatf("anim_base_v%0d", i), {19'd0, anim_base}, {19'd0, vecs[i].exp_base});
      end

      // Restart from READY while showing frame 2, with a tick in the same cycle.
      $display("[TB] restart during READY");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
      checkOutput("restart_done", {31'd0, done}, 32'd0);
      checkOutput("restart_anim_idx", {30'd0, anim_idx}, 32'd1);
      checkOutput("restart_anim_base", {19'd0, anim_base}, 32'd1750);
      checkOutput("restart_src_ready", {31'd0, src_ready}, 32'd1);
      acc_cnt = 0;
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h5A00 + 16'(acc_cnt));
      checkOutput("reload_wr_addr", {19'd0, wr_addr}, 32'd11);
      checkOutput("reload_wr_data", {16'd0, wr_data}, 32'h5A0B);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
